// File: rtl/exec_sequencer_if.sv
// Fetch, ALU and memory signal bundle between exec_sequencer (master) and
// the instruction source, ALU and memory around it (slave).
interface exec_sequencer_if;
  logic       instr_req;
  logic       instr_valid;
  logic [7:0] instr_in;
  logic [1:0] alu_opcode;
  logic [3:0] alu_addrs;
  logic [7:0] alu_din0;
  logic [7:0] alu_din1;
  logic [7:0] alu_dout;
  logic       alu_carry;
  logic       alu_borrow;
  logic       alu_carry_en;
  logic       alu_bcf;
  logic       alu_mem_write;
  logic       alu_mem_read;
  logic       alu_toggle;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  modport master (
    output instr_req, alu_opcode, alu_addrs, alu_din0, alu_din1,
           mem_req, mem_we, mem_addr, mem_wdata,
    input  instr_valid, instr_in, alu_dout, alu_carry, alu_borrow, alu_carry_en,
           alu_bcf, alu_mem_write, alu_mem_read, alu_toggle, mem_rdata, mem_ack
  );

  modport slave (
    input  instr_req, alu_opcode, alu_addrs, alu_din0, alu_din1,
           mem_req, mem_we, mem_addr, mem_wdata,
    output instr_valid, instr_in, alu_dout, alu_carry, alu_borrow, alu_carry_en,
           alu_bcf, alu_mem_write, alu_mem_read, alu_toggle, mem_rdata, mem_ack
  );
endinterface

// File: rtl/exec_sequencer.sv
// Fetch/execute sequencer feeding a combinational ALU: fetches instructions,
// drives operands from a 4x8 register file and retires ALU results.
module exec_sequencer #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] PC_RESET = {PC_WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  exec_sequencer_if.master        bus,
  output logic [PC_WIDTH-1:0]     pc_out,
  output logic                    cflag,
  output logic                    toggle_out,
  output logic [1:0]              state_dbg
);
  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, MEM = 2'd2} state_t;

  state_t              state_r, nextState_s;
  logic [PC_WIDTH-1:0] pc_r, nextPc_s;
  logic [5:0]          ir_r, nextIr_s;
  logic [7:0]          regFile_r [4];
  logic                regWe_s;
  logic [7:0]          regWdata_s;
  logic                cflag_r, nextCflag_s;
  logic                toggle_r, nextToggle_s;
  logic                memReq_r;
  logic                memWe_r, nextMemWe_s;
  logic [7:0]          memAddr_r, nextMemAddr_s;
  logic [7:0]          memWdata_r, nextMemWdata_s;
  logic [1:0]          dst_s, src1_s;

  // IR holds only opcode and addrs; the two low instruction bits carry nothing.
  assign dst_s          = ir_r[3:2];
  assign src1_s         = ir_r[1:0];
  assign bus.alu_opcode = ir_r[5:4];
  assign bus.alu_addrs  = ir_r[3:0];
  assign bus.alu_din0   = regFile_r[dst_s];
  assign bus.alu_din1   = regFile_r[src1_s];
  assign bus.instr_req  = run && (state_r == FETCH);
  assign bus.mem_req    = memReq_r;
  assign bus.mem_we     = memWe_r;
  assign bus.mem_addr   = memAddr_r;
  assign bus.mem_wdata  = memWdata_r;
  assign pc_out         = pc_r;
  assign cflag          = cflag_r;
  assign toggle_out     = toggle_r;
  assign state_dbg      = state_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state and datapath-update decode
  always_comb begin
    nextState_s    = state_r;
    nextPc_s       = pc_r;
    nextIr_s       = ir_r;
    regWe_s        = 1'b0;
    regWdata_s     = bus.alu_dout;
    nextCflag_s    = cflag_r;
    nextToggle_s   = toggle_r;
    nextMemWe_s    = memWe_r;
    nextMemAddr_s  = memAddr_r;
    nextMemWdata_s = memWdata_r;
    case (state_r)
      FETCH: begin
        if (run && bus.instr_valid) begin
          nextIr_s    = bus.instr_in[7:2];
          nextState_s = EXEC;
        end else begin
          nextState_s = FETCH;
        end
      end
      EXEC: begin
        if (bus.alu_mem_write || bus.alu_mem_read) begin
          nextMemWe_s    = bus.alu_mem_write;
          nextMemAddr_s  = bus.alu_dout;
          nextMemWdata_s = regFile_r[dst_s];
          nextState_s    = MEM;
        end else if (bus.alu_bcf) begin
          // Branch decision uses the flag as it stood before this instruction.
          if (cflag_r) begin
            nextPc_s = PC_WIDTH'(bus.alu_dout);
          end else begin
            nextPc_s = pc_r + PC_WIDTH'(1);
          end
          nextState_s = FETCH;
        end else begin
          regWe_s     = 1'b1;
          regWdata_s  = bus.alu_dout;
          nextPc_s    = pc_r + PC_WIDTH'(1);
          nextState_s = FETCH;
        end
        if (bus.alu_carry_en) begin
          nextCflag_s = bus.alu_carry | bus.alu_borrow;
        end else begin
          nextCflag_s = cflag_r;
        end
        if (bus.alu_toggle) begin
          nextToggle_s = ~toggle_r;
        end else begin
          nextToggle_s = toggle_r;
        end
      end
      MEM: begin
        if (bus.mem_ack) begin
          if (!memWe_r) begin
            regWe_s    = 1'b1;
            regWdata_s = bus.mem_rdata;
          end else begin
            regWe_s    = 1'b0;
          end
          nextPc_s    = pc_r + PC_WIDTH'(1);
          nextState_s = FETCH;
        end else begin
          nextState_s = MEM;
        end
      end
      default: begin
        nextState_s = FETCH;
      end
    endcase
  end

  // Datapath registers, register file and memory-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= PC_RESET;
      ir_r       <= 6'd0;
      cflag_r    <= 1'b0;
      toggle_r   <= 1'b0;
      memReq_r   <= 1'b0;
      memWe_r    <= 1'b0;
      memAddr_r  <= 8'h00;
      memWdata_r <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        regFile_r[i] <= 8'h00;
      end
    end else begin
      pc_r       <= nextPc_s;
      ir_r       <= nextIr_s;
      cflag_r    <= nextCflag_s;
      toggle_r   <= nextToggle_s;
      memReq_r   <= (nextState_s == MEM);
      memWe_r    <= nextMemWe_s;
      memAddr_r  <= nextMemAddr_s;
      memWdata_r <= nextMemWdata_s;
      if (regWe_s) begin
        regFile_r[dst_s] <= regWdata_s;
      end
    end
  end
endmodule

// File: tb/tb_exec_sequencer.sv
// Directed scoreboard bench for exec_sequencer: the bench plays the ALU and
// memory, keeps a reference model of the architectural state and compares it.
module tb_exec_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] pc_out;
  logic       cflag;
  logic       toggle_out;
  logic [1:0] state_dbg;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mReg [4];
  logic [7:0] mPc;
  logic       mCflag;
  logic       mTog;

  string       sbTag [$];
  int          sbKind [$];
  logic [31:0] sbExp [$];

  exec_sequencer_if bus ();

  exec_sequencer #(.PC_WIDTH(8), .PC_RESET(8'h00)) dut (
    .clk(clk), .rst(rst), .run(run), .bus(bus),
    .pc_out(pc_out), .cflag(cflag), .toggle_out(toggle_out), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int k);
    case (k)
      0: return {24'h0, dut.regFile_r[0]};
      1: return {24'h0, dut.regFile_r[1]};
      2: return {24'h0, dut.regFile_r[2]};
      3: return {24'h0, dut.regFile_r[3]};
      4: return {24'h0, pc_out};
      5: return {31'h0, cflag};
      6: return {31'h0, toggle_out};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input logic [31:0] exp);
    sbTag.push_back(tag);
    sbKind.push_back(kind);
    sbExp.push_back(exp);
  endtask

  // Queue the whole expected architectural state from the model.
  task automatic expectAll(input string step);
    push({step, "_r0"}, 0, {24'h0, mReg[0]});
    push({step, "_r1"}, 1, {24'h0, mReg[1]});
    push({step, "_r2"}, 2, {24'h0, mReg[2]});
    push({step, "_r3"}, 3, {24'h0, mReg[3]});
    push({step, "_pc"}, 4, {24'h0, mPc});
    push({step, "_cflag"}, 5, {31'h0, mCflag});
    push({step, "_toggle"}, 6, {31'h0, mTog});
  endtask

  task automatic drain();
    while (sbKind.size() > 0) begin
      string       t;
      int          k;
      logic [31:0] e;
      t = sbTag.pop_front();
      k = sbKind.pop_front();
      e = sbExp.pop_front();
      chk(t, observe(k), e);
    end
  endtask

  task automatic clearAlu();
    bus.alu_dout      = 8'h00;
    bus.alu_carry     = 1'b0;
    bus.alu_borrow    = 1'b0;
    bus.alu_carry_en  = 1'b0;
    bus.alu_bcf       = 1'b0;
    bus.alu_mem_write = 1'b0;
    bus.alu_mem_read  = 1'b0;
    bus.alu_toggle    = 1'b0;
  endtask

  // Present one instruction plus the ALU's answer; returns one cycle after EXEC.
  task automatic exec(input logic [7:0] instr, input logic [7:0] dout,
                      input logic carry, input logic borrow, input logic cen,
                      input logic bcf, input logic mw, input logic mr, input logic tog);
    logic [1:0] d;
    logic [1:0] s;
    d = instr[5:4];
    s = instr[3:2];
    @(negedge clk);
    run = 1'b1;
    bus.instr_valid   = 1'b1;
    bus.instr_in      = instr;
    bus.alu_dout      = dout;
    bus.alu_carry     = carry;
    bus.alu_borrow    = borrow;
    bus.alu_carry_en  = cen;
    bus.alu_bcf       = bcf;
    bus.alu_mem_write = mw;
    bus.alu_mem_read  = mr;
    bus.alu_toggle    = tog;
    @(negedge clk);
    chk("exec_state", {30'h0, state_dbg}, 32'd1);
    chk("exec_instr_req", {31'h0, bus.instr_req}, 32'd0);
    chk("exec_opcode", {30'h0, bus.alu_opcode}, {30'h0, instr[7:6]});
    chk("exec_addrs", {28'h0, bus.alu_addrs}, {28'h0, instr[5:2]});
    chk("exec_din0", {24'h0, bus.alu_din0}, {24'h0, mReg[d]});
    chk("exec_din1", {24'h0, bus.alu_din1}, {24'h0, mReg[s]});
    bus.instr_valid = 1'b0;
    @(negedge clk);
    clearAlu();
  endtask

  // Hold off the ack for a number of cycles, then complete the access.
  task automatic memAck(input int waits, input logic [7:0] rdata, input logic expWe);
    for (int i = 0; i < waits; i++) begin
      chk("mem_req_wait", {31'h0, bus.mem_req}, 32'd1);
      chk("mem_we_wait", {31'h0, bus.mem_we}, {31'h0, expWe});
      @(negedge clk);
    end
    chk("mem_req_ack", {31'h0, bus.mem_req}, 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("mem_req_drop", {31'h0, bus.mem_req}, 32'd0);
    chk("mem_done_state", {30'h0, state_dbg}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_in    = 8'h00;
    bus.mem_rdata   = 8'h00;
    bus.mem_ack     = 1'b0;
    clearAlu();
    for (int i = 0; i < 4; i++) mReg[i] = 8'h00;
    mPc = 8'h00;
    mCflag = 1'b0;
    mTog = 1'b0;

    // Reset / idle
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'h0, bus.mem_req}, 32'd0);
    chk("rst_instr_req", {31'h0, bus.instr_req}, 32'd0);
    chk("rst_state", {30'h0, state_dbg}, 32'd0);
    expectAll("rst");
    drain();
    rst = 1'b0;

    // Preload r0 and r1 through memory reads
    exec(8'h00, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ld0_mem_we", {31'h0, bus.mem_we}, 32'd0);
    chk("ld0_mem_addr", {24'h0, bus.mem_addr}, 32'h40);
    memAck(0, 8'hF0, 1'b0);
    mReg[0] = 8'hF0; mPc = 8'h01;
    expectAll("ld0");
    drain();
    exec(8'h10, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    memAck(0, 8'h20, 1'b0);
    mReg[1] = 8'h20; mPc = 8'h02;
    expectAll("ld1");
    drain();

    // Add with carry: r0 = 0xF0 + 0x20
    exec(8'h04, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add_latency_instr_req", {31'h0, bus.instr_req}, 32'd1);
    mReg[0] = 8'h10; mCflag = 1'b1; mPc = 8'h03;
    expectAll("add");
    drain();

    // Branch taken with cflag=1
    exec(8'hC0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    mPc = 8'h3C;
    expectAll("bcf_taken");
    drain();

    // Clear cflag, then branch not taken
    exec(8'h70, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    mReg[3] = 8'h77; mCflag = 1'b0; mPc = 8'h3D;
    expectAll("clr_c");
    drain();
    exec(8'hC0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    mPc = 8'h3E;
    expectAll("bcf_not");
    drain();

    // Memory read to r2 with a 5-cycle ack wait
    exec(8'hA0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rd_mem_addr", {24'h0, bus.mem_addr}, 32'h55);
    memAck(5, 8'hA5, 1'b0);
    mReg[2] = 8'hA5; mPc = 8'h3F;
    expectAll("rd_wait");
    drain();

    // Write and read both set: write wins, no register update
    exec(8'h01, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("wr_mem_we", {31'h0, bus.mem_we}, 32'd1);
    chk("wr_mem_addr", {24'h0, bus.mem_addr}, 32'h99);
    chk("wr_mem_wdata", {24'h0, bus.mem_wdata}, 32'h10);
    memAck(1, 8'hEE, 1'b1);
    mPc = 8'h40;
    expectAll("wr_both");
    drain();

    // Set cflag via borrow, branch to 0xFF, then wrap with toggle
    exec(8'h70, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    mReg[3] = 8'h33; mCflag = 1'b1; mPc = 8'h41;
    expectAll("borrow");
    drain();
    exec(8'hC0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    mPc = 8'hFF;
    expectAll("bcf_ff");
    drain();
    exec(8'h94, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mReg[1] = 8'h5A; mPc = 8'h00; mTog = 1'b1;
    expectAll("wrap_tog");
    drain();

    // run=0 in FETCH: instr_valid ignored, pc holds
    run = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr_in    = 8'hC4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_instr_req", {31'h0, bus.instr_req}, 32'd0);
      chk("idle_state", {30'h0, state_dbg}, 32'd0);
    end
    bus.instr_valid = 1'b0;
    expectAll("idle");
    drain();

    // Reset during a pending memory access, then a late ack
    exec(8'hA0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run = 1'b0;
    chk("rstmem_req_before", {31'h0, bus.mem_req}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmem_mem_req", {31'h0, bus.mem_req}, 32'd0);
    chk("rstmem_state", {30'h0, state_dbg}, 32'd0);
    for (int i = 0; i < 4; i++) mReg[i] = 8'h00;
    mPc = 8'h00; mCflag = 1'b0; mTog = 1'b0;
    expectAll("rstmem");
    drain();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'hCC;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("late_ack_state", {30'h0, state_dbg}, 32'd0);
    chk("late_ack_mem_req", {31'h0, bus.mem_req}, 32'd0);
    expectAll("late_ack");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Fetch/execute sequencer that sits directly upstream of the ALU. It fetches 8-bit instructions over a request/valid handshake and decodes opcode and addrs. It drives ALU operands from a 4x8 register file, then consumes the ALU's result and side-band flags to do register writeback, carry-flag update, conditional branch, external memory access and the toggle output. It is the only sequential control in the core; the ALU stays purely combinational.

Parameters:
PC_WIDTH, 8, program counter width; pc wraps modulo 2^PC_WIDTH
PC_RESET, 0, pc value loaded on reset

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
run  input  1  enables instruction fetch; sampled in FETCH only
instr_req  output  1  high in FETCH while run=1
instr_valid  input  1  instruction byte on instr_in valid this cycle
instr_in  input  8  [7:6] opcode, [5:2] addrs, [1:0] ignored
pc_out  output  PC_WIDTH  current program counter
alu_opcode  output  2  to ALU opcode (from IR[7:6])
alu_addrs  output  4  to ALU addrs (from IR[5:2])
alu_din0  output  8  reg[addrs[3:2]] (dst/src0)
alu_din1  output  8  reg[addrs[1:0]] (src1)
alu_dout  input  8  ALU result
alu_carry, alu_borrow, alu_carry_en, alu_bcf, alu_mem_write, alu_mem_read, alu_toggle  input  1 each  ALU side-band flags
mem_req  output  1  memory access in progress
mem_we  output  1  1=write, 0=read; valid while mem_req
mem_addr  output  8  latched alu_dout
mem_wdata  output  8  latched reg[dst]
mem_rdata  input  8  read data, valid with mem_ack
mem_ack  input  1  completes access
cflag  output  1  carry/borrow flag
toggle_out  output  1  toggle register
state_dbg  output  2  FSM state (FETCH=0, EXEC=1, MEM=2)

Behaviour:
- Reset (rst high at an edge): state=FETCH, pc=PC_RESET, IR=0, all regs=0, cflag=0, toggle_out=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset overrides everything, including an in-flight MEM access; mem_req is low the cycle after the reset edge.
- alu_opcode, alu_addrs, alu_din0, alu_din1 are driven combinationally from IR and the register file in every state.
- FETCH: instr_req=run. If run and instr_valid, then IR<=instr_in and go to EXEC. Otherwise hold. instr_valid is ignored when run=0.
- EXEC (one cycle), evaluated in this priority order:
  1. If alu_mem_write or alu_mem_read: mem_we<=alu_mem_write (write wins if both are set), mem_addr<=alu_dout, mem_wdata<=reg[dst], go to MEM. pc is unchanged.
  2. Else if alu_bcf: if cflag=1 (the value before this cycle), pc<=alu_dout[PC_WIDTH-1:0], else pc<=pc+1. No register write. Go to FETCH.
  3. Else: reg[dst]<=alu_dout, pc<=pc+1, go to FETCH.
  - In parallel with the above: if alu_carry_en, cflag<=alu_carry|alu_borrow; otherwise cflag holds. If alu_toggle, toggle_out<=~toggle_out.
- MEM: mem_req=1. mem_we, mem_addr and mem_wdata stay stable until ack. On mem_ack: for a read, reg[dst]<=mem_rdata; then pc<=pc+1, go to FETCH, and mem_req drops the next cycle. No timeout.
- Latency: a non-memory instruction takes 2 cycles from instr_valid to the next instr_req, assuming run stays high. A memory instruction takes 2 cycles plus the ack wait.
- pc+1 wraps from 2^PC_WIDTH-1 to 0. A branch target is truncated/zero-extended to PC_WIDTH.
- dst==src1 is legal: reads use pre-edge values.

Test Plan:
- Reset/idle: assert rst for 2 cycles with run=0 -> pc_out=0, cflag=0, toggle_out=0, mem_req=0, instr_req=0, state_dbg=0.
- Add with carry: preload r0=0xF0, r1=0x20 via mem reads, then issue opcode0 dst=0, src1=1 with ALU model returning dout=0x10, carry=1, carry_en=1 -> r0=0x10, cflag=1, pc increments by 1, instr_req is asserted 2 cycles after instr_valid.
- Branch: with cflag=1, issue bcf returning dout=0x3C -> pc=0x3C, no register changes. Repeat with cflag=0 -> pc=old+1.
- Memory read with wait: read to r2, ack held off 5 cycles with mem_rdata=0xA5 -> mem_req high for exactly those cycles, mem_we=0, r2=0xA5 after ack. If mem_write and mem_read are both set -> mem_we=1.
- Reset mid-MEM: pulse rst during a pending access -> mem_req=0 next cycle, pc=0, state=FETCH, and a late mem_ack is ignored.
- Wrap/toggle: with pc=0xFF, execute xor with toggle=1 -> pc=0x00, toggle_out inverts. run=0 in FETCH holds pc, and instr_valid is ignored.
